// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM states and generator defaults.
package pwm_pkg;

  typedef enum logic {IDLE, MEASURE} pwm_cap_state_t;

  localparam int PWM_DEFAULT_WIDTH = 16;
  localparam int PWM_DEFAULT_PERIOD = 1 << (PWM_DEFAULT_WIDTH - 1);

endpackage

// File: rtl/pwm_input_conditioner.sv
// Synchroniser, optional deglitch filter and rising-edge detector.
// Deglitch stage present when PWM_CAPTURE_GLITCH_FILTER_EN is defined.
module pwm_input_conditioner
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  #(
    parameter int FILTER_CYCLES = 4
  )
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic lvl,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      prev_q  <= lvl;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic          filt_q;
  logic          filt_d;
  logic [CW-1:0] run_q;
  logic [CW-1:0] run_d;

  // run_q counts consecutive samples that disagree with the filtered level
  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    if (sync2_q != filt_q) begin
      if (run_q == CW'(FILTER_CYCLES - 1)) begin
        filt_d = sync2_q;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= 1'b0;
      run_q  <= '0;
    end else begin
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  assign rise = lvl & ~prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an incoming waveform.
// Optional deglitch filter enabled by PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH         = PWM_DEFAULT_WIDTH,
  parameter int TIMEOUT       = 65535,
  parameter int FILTER_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] measured_period,
  output logic [WIDTH-1:0] measured_high,
  output logic             measurement_valid,
  output logic             period_start,
  output logic             level_stuck,
  output logic             stuck_level
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] TO      = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic lvl;
  logic rise;

  pwm_input_conditioner
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    #(.FILTER_CYCLES(FILTER_CYCLES))
`endif
    u_cond (
      .clk    (clk),
      .reset  (reset),
      .pwm_in (pwm_in),
      .lvl    (lvl),
      .rise   (rise)
    );

  pwm_cap_state_t   state_q, state_d;
  logic [WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic [WIDTH-1:0] high_cnt_q, high_cnt_d;
  logic [WIDTH-1:0] meas_period_q, meas_period_d;
  logic [WIDTH-1:0] meas_high_q, meas_high_d;
  logic             valid_q, valid_d;
  logic             start_q, start_d;
  logic             stuck_q, stuck_d;
  logic             stuck_lvl_q, stuck_lvl_d;

  always_comb begin
    state_d       = state_q;
    period_cnt_d  = period_cnt_q;
    high_cnt_d    = high_cnt_q;
    meas_period_d = meas_period_q;
    meas_high_d   = meas_high_q;
    valid_d       = 1'b0;
    start_d       = 1'b0;
    stuck_d       = stuck_q;
    stuck_lvl_d   = stuck_lvl_q;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d      = MEASURE;
          period_cnt_d = ONE;
          high_cnt_d   = ONE;
          start_d      = 1'b1;
          stuck_d      = 1'b0;
        end else begin
          // period_cnt doubles as the idle timeout counter
          if (period_cnt_q != CNT_MAX) begin
            period_cnt_d = period_cnt_q + ONE;
          end
          if (!stuck_q && period_cnt_q >= TO) begin
            stuck_d     = 1'b1;
            stuck_lvl_d = lvl;
          end
        end
      end
      MEASURE: begin
        if (rise) begin
          meas_period_d = period_cnt_q;
          meas_high_d   = high_cnt_q;
          valid_d       = 1'b1;
          start_d       = 1'b1;
          period_cnt_d  = ONE;
          high_cnt_d    = ONE;
        end else if (period_cnt_q == TO) begin
          state_d     = IDLE;
          stuck_d     = 1'b1;
          stuck_lvl_d = lvl;
        end else begin
          if (period_cnt_q != CNT_MAX) begin
            period_cnt_d = period_cnt_q + ONE;
          end
          if (lvl && high_cnt_q != CNT_MAX) begin
            high_cnt_d = high_cnt_q + ONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      period_cnt_q  <= '0;
      high_cnt_q    <= '0;
      meas_period_q <= '0;
      meas_high_q   <= '0;
      valid_q       <= 1'b0;
      start_q       <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_lvl_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_cnt_q  <= period_cnt_d;
      high_cnt_q    <= high_cnt_d;
      meas_period_q <= meas_period_d;
      meas_high_q   <= meas_high_d;
      valid_q       <= valid_d;
      start_q       <= start_d;
      stuck_q       <= stuck_d;
      stuck_lvl_q   <= stuck_lvl_d;
    end
  end

  assign measured_period   = meas_period_q;
  assign measured_high     = meas_high_q;
  assign measurement_valid = valid_q;
  assign period_start      = start_q;
  assign level_stuck       = stuck_q;
  assign stuck_level       = stuck_lvl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed scenarios plus random waveforms
// checked against an edge-list model of the sampled input.
module tb_pwm_capture;

  localparam int W  = 16;
  localparam int TO = 50;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FILT = 4;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pwm_in = 1'b0;
  logic [W-1:0] measured_period;
  logic [W-1:0] measured_high;
  logic         measurement_valid;
  logic         period_start;
  logic         level_stuck;
  logic         stuck_level;

  int checks = 0;
  int failures = 0;
  int samp[$];
  int got_p[$];
  int got_h[$];
  int exp_p[$];
  int exp_h[$];
  int n_start = 0;
  int exp_rises;
  int g0;
  int s0;

  pwm_capture #(
    .WIDTH         (W),
    .TIMEOUT       (TO),
    .FILTER_CYCLES (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .pwm_in            (pwm_in),
    .measured_period   (measured_period),
    .measured_high     (measured_high),
    .measurement_valid (measurement_valid),
    .period_start      (period_start),
    .level_stuck       (level_stuck),
    .stuck_level       (stuck_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (measurement_valid) begin
        got_p.push_back(int'(measured_period));
        got_h.push_back(int'(measured_high));
      end
      if (period_start) n_start++;
    end
  end

  task automatic put(input int v);
    @(negedge clk);
    pwm_in = v[0];
    samp.push_back(v);
  endtask

  task automatic drive(input int p, input int h, input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < p; j++) put(j < h ? 1 : 0);
  endtask

  task automatic settle();
    int v;
    v = (samp.size() > 0) ? samp[$] : 0;
    repeat (12) put(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    samp.delete();
    g0 = got_p.size();
    s0 = n_start;
  endtask

  // Reference: list rising edges of the (optionally filtered) level,
  // pair consecutive edges whose gap does not exceed the timeout.
  task automatic model();
    int f[$];
    int cur;
    int last;
    int run;
    cur = 0;
    last = -1;
    run = 0;
    exp_p.delete();
    exp_h.delete();
    exp_rises = 0;
    foreach (samp[k]) begin
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      if (samp[k] != cur) begin
        run++;
        if (run == FILT) begin
          cur = samp[k];
          run = 0;
        end
      end else begin
        run = 0;
      end
`else
      cur = samp[k];
`endif
      f.push_back(cur);
    end
    for (int k = 0; k < f.size(); k++) begin
      if (f[k] == 1 && (k == 0 || f[k-1] == 0)) begin
        exp_rises++;
        if (last >= 0 && k - last <= TO) begin
          int h;
          h = 0;
          for (int m = last; m < k; m++) h += f[m];
          exp_p.push_back(k - last);
          exp_h.push_back(h);
        end
        last = k;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (measured_period !== 0) begin
      failures++;
      $display("FAIL reset_period got=%0d exp=0", measured_period);
    end
    checks++;
    if (measured_high !== 0) begin
      failures++;
      $display("FAIL reset_high got=%0d exp=0", measured_high);
    end
    checks++;
    if (measurement_valid !== 0) begin
      failures++;
      $display("FAIL reset_valid got=%0b exp=0", measurement_valid);
    end
    checks++;
    if (period_start !== 0) begin
      failures++;
      $display("FAIL reset_start got=%0b exp=0", period_start);
    end
    checks++;
    if (level_stuck !== 0) begin
      failures++;
      $display("FAIL reset_stuck got=%0b exp=0", level_stuck);
    end
    checks++;
    if (stuck_level !== 0) begin
      failures++;
      $display("FAIL reset_stuck_level got=%0b exp=0", stuck_level);
    end
  endtask

  task automatic test_loopback();
    do_reset();
    drive(10, 3, 6);
    settle();
    checks++;
    if (got_p.size() - g0 != 5) begin
      failures++;
      $display("FAIL loop_count got=%0d exp=5", got_p.size() - g0);
    end
    for (int i = g0; i < got_p.size(); i++) begin
      checks++;
      if (got_p[i] != 10 || got_h[i] != 3) begin
        failures++;
        $display("FAIL loop_meas got=%0d/%0d exp=10/3", got_p[i], got_h[i]);
      end
    end
    checks++;
    if (n_start - s0 != 6) begin
      failures++;
      $display("FAIL loop_starts got=%0d exp=6", n_start - s0);
    end
  endtask

  task automatic test_param_change();
    int ep;
    int eh;
    do_reset();
    drive(10, 3, 3);
    drive(20, 15, 4);
    settle();
    checks++;
    if (got_p.size() - g0 != 6) begin
      failures++;
      $display("FAIL chg_count got=%0d exp=6", got_p.size() - g0);
    end
    for (int i = 0; g0 + i < got_p.size(); i++) begin
      ep = (i < 3) ? 10 : 20;
      eh = (i < 3) ? 3 : 15;
      checks++;
      if (got_p[g0+i] != ep || got_h[g0+i] != eh) begin
        failures++;
        $display("FAIL chg_meas[%0d] got=%0d/%0d exp=%0d/%0d",
                 i, got_p[g0+i], got_h[g0+i], ep, eh);
      end
    end
  endtask

  task automatic test_stuck_low();
    do_reset();
    repeat (70) put(0);
    checks++;
    if (level_stuck !== 1'b1 || stuck_level !== 1'b0) begin
      failures++;
      $display("FAIL stuck_low got=%0b/%0b exp=1/0", level_stuck, stuck_level);
    end
    checks++;
    if (got_p.size() != g0) begin
      failures++;
      $display("FAIL stuck_low_valid got=%0d exp=0", got_p.size() - g0);
    end
    drive(8, 5, 5);
    settle();
    checks++;
    if (level_stuck !== 1'b0) begin
      failures++;
      $display("FAIL stuck_clear got=%0b exp=0", level_stuck);
    end
    checks++;
    if (got_p.size() - g0 != 4) begin
      failures++;
      $display("FAIL recover_count got=%0d exp=4", got_p.size() - g0);
    end
    for (int i = g0; i < got_p.size(); i++) begin
      checks++;
      if (got_p[i] != 8 || got_h[i] != 5) begin
        failures++;
        $display("FAIL recover_meas got=%0d/%0d exp=8/5", got_p[i], got_h[i]);
      end
    end
  endtask

  task automatic test_stuck_high();
    do_reset();
    drive(8, 8, 9);
    checks++;
    if (level_stuck !== 1'b1 || stuck_level !== 1'b1) begin
      failures++;
      $display("FAIL stuck_high got=%0b/%0b exp=1/1", level_stuck, stuck_level);
    end
    checks++;
    if (got_p.size() != g0 || n_start - s0 != 1) begin
      failures++;
      $display("FAIL stuck_high_events got=%0d/%0d exp=0/1",
               got_p.size() - g0, n_start - s0);
    end
  endtask

  task automatic test_timeout_boundary();
    do_reset();
    drive(50, 10, 3);
    settle();
    checks++;
    if (got_p.size() - g0 != 2) begin
      failures++;
      $display("FAIL to50_count got=%0d exp=2", got_p.size() - g0);
    end
    for (int i = g0; i < got_p.size(); i++) begin
      checks++;
      if (got_p[i] != 50 || got_h[i] != 10) begin
        failures++;
        $display("FAIL to50_meas got=%0d/%0d exp=50/10", got_p[i], got_h[i]);
      end
    end
    checks++;
    if (level_stuck !== 1'b1 || stuck_level !== 1'b0) begin
      failures++;
      $display("FAIL to50_tail got=%0b/%0b exp=1/0", level_stuck, stuck_level);
    end
    do_reset();
    drive(51, 10, 3);
    settle();
    checks++;
    if (got_p.size() != g0 || n_start - s0 != 3) begin
      failures++;
      $display("FAIL to51_events got=%0d/%0d exp=0/3",
               got_p.size() - g0, n_start - s0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(10, 3, 3);
    put(1);
    put(1);
    put(1);
    put(0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (measured_period !== 0 || measured_high !== 0 ||
        measurement_valid !== 0 || period_start !== 0) begin
      failures++;
      $display("FAIL mid_reset got=%0d/%0d/%0b/%0b exp=0/0/0/0",
               measured_period, measured_high, measurement_valid, period_start);
    end
    do_reset();
    drive(10, 3, 4);
    settle();
    checks++;
    if (got_p.size() - g0 != 3) begin
      failures++;
      $display("FAIL mid_count got=%0d exp=3", got_p.size() - g0);
    end
    if (got_p.size() > g0) begin
      checks++;
      if (got_p[g0] != 10 || got_h[g0] != 3) begin
        failures++;
        $display("FAIL mid_first got=%0d/%0d exp=10/3", got_p[g0], got_h[g0]);
      end
    end
  endtask

  task automatic test_glitch();
    int ecount;
    int ep0;
    int eh0;
    int ep1;
    int eh1;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    ecount = 4; ep0 = 20; eh0 = 8; ep1 = 20; eh1 = 8;
`else
    ecount = 9; ep0 = 12; eh0 = 8; ep1 = 8; eh1 = 2;
`endif
    do_reset();
    for (int n = 0; n < 5; n++) begin
      repeat (8) put(1);
      repeat (4) put(0);
      repeat (2) put(1);
      repeat (6) put(0);
    end
    settle();
    checks++;
    if (got_p.size() - g0 != ecount) begin
      failures++;
      $display("FAIL glitch_count got=%0d exp=%0d", got_p.size() - g0, ecount);
    end
    if (got_p.size() - g0 >= 2) begin
      checks++;
      if (got_p[g0] != ep0 || got_h[g0] != eh0 ||
          got_p[g0+1] != ep1 || got_h[g0+1] != eh1) begin
        failures++;
        $display("FAIL glitch_meas got=%0d/%0d,%0d/%0d exp=%0d/%0d,%0d/%0d",
                 got_p[g0], got_h[g0], got_p[g0+1], got_h[g0+1],
                 ep0, eh0, ep1, eh1);
      end
    end
  endtask

  task automatic test_random();
    int p;
    int h;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int s = 0; s < 8; s++) begin
        if ($urandom_range(0, 7) == 0) repeat (60) put(0);
        p = $urandom_range(8, 40);
        h = $urandom_range(4, p - 4);
        drive(p, h, $urandom_range(1, 4));
      end
      settle();
      model();
      checks++;
      if (got_p.size() - g0 != exp_p.size()) begin
        failures++;
        $display("FAIL rand_count got=%0d exp=%0d", got_p.size() - g0, exp_p.size());
      end
      for (int i = 0; i < exp_p.size() && g0 + i < got_p.size(); i++) begin
        checks++;
        if (got_p[g0+i] != exp_p[i] || got_h[g0+i] != exp_h[i]) begin
          failures++;
          $display("FAIL rand_meas[%0d] got=%0d/%0d exp=%0d/%0d",
                   i, got_p[g0+i], got_h[g0+i], exp_p[i], exp_h[i]);
        end
      end
      checks++;
      if (n_start - s0 != exp_rises) begin
        failures++;
        $display("FAIL rand_starts got=%0d exp=%0d", n_start - s0, exp_rises);
      end
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_param_change();
    test_stuck_low();
    test_stuck_high();
    test_timeout_boundary();
    test_reset_mid();
    test_glitch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart to the PWM generator: measures period and high time of an incoming PWM waveform, in clk cycles.
- Input may be asynchronous. It is synchronised, rising edges are detected, and one (period, high_time) pair is reported per completed period with a one-cycle valid strobe.
- A waveform held at a constant level (0% / 100% duty) is detected by timeout.
- Used for loopback checking of the generator and for decoding external PWM sensors.

Parameters:
- WIDTH, 16, width of the period and high-time counters and outputs.
- TIMEOUT, 65535, cycles without a rising edge before level_stuck asserts; must be >= 2 and <= 2**WIDTH-1.
- FILTER_CYCLES, 4, consecutive equal samples required to accept a level change (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset; clock is clk; reset is synchronous, active-high
- pwm_in  in  1  PWM input, asynchronous to clk
- measured_period  out  WIDTH  cycles from previous rising edge to latest rising edge
- measured_high  out  WIDTH  cycles the input was high within that period
- measurement_valid  out  1  one-cycle pulse when the measured_* outputs update
- period_start  out  1  one-cycle pulse on every accepted rising edge
- level_stuck  out  1  high while no rising edge has occurred for TIMEOUT cycles
- stuck_level  out  1  sampled input level when level_stuck rose; meaningful only while level_stuck=1

Behaviour:
- Synchroniser: 2-flop sync on pwm_in, giving `lvl`. `prev` holds `lvl` delayed one cycle. A rising edge is `rise = lvl & ~prev`. Latency from pin to `rise` is 2-3 cycles; this is constant and does not affect measured values.
- Reset: state=IDLE. All outputs are 0. Counters, sync flops and `prev` are 0.
- IDLE state: waits for the first `rise`; a partial period after reset is discarded.
  - On `rise`: set period_cnt=1, high_cnt=1, pulse period_start, go to MEASURE. measurement_valid stays 0.
- MEASURE state, each cycle without `rise`:
  - period_cnt += 1.
  - high_cnt += lvl.
  - Both counters saturate at 2**WIDTH-1 and never wrap.
- MEASURE state, cycle with `rise`:
  - measured_period <= period_cnt.
  - measured_high <= high_cnt.
  - measurement_valid=1 and period_start=1 for this cycle.
  - period_cnt<=1, high_cnt<=1; the edge cycle counts as the first cycle of the new period.
  - Result: a generator with period P and duty H yields measured_period=P and measured_high=H, for 1 <= H <= P-1.
- Timeout: in MEASURE, when period_cnt reaches TIMEOUT without a `rise`:
  - level_stuck<=1 and stuck_level<=lvl.
  - No valid pulse is issued.
  - Go to IDLE.
  - measured_* keep their previous values.
- Also in IDLE, after TIMEOUT cycles without a `rise` (idle counter reuses period_cnt): level_stuck<=1, stuck_level<=lvl.
- level_stuck clears on the next `rise`, in the same cycle as period_start.
- measured_* hold their value between valid pulses.
- Period of 1 cycle or duty of 0/P: no rising edges occur, so this is reported via level_stuck, not via a measurement.
- Duty H=P: same as above.
- Minimum measurable period is 2 cycles.
- Reset asserted mid-period: measurement is abandoned, IDLE is entered, and no valid pulse is issued.
- Simultaneous `rise` and period_cnt==TIMEOUT: `rise` wins; a normal measurement is reported.

Optional Feature:
- Macro: PWM_CAPTURE_GLITCH_FILTER_EN.
- Defined: a deglitch stage sits between the synchroniser and `lvl`.
  - `lvl` changes only after the synchronised input has held the new value for FILTER_CYCLES consecutive cycles.
  - Pulses (high or low) shorter than FILTER_CYCLES are ignored.
  - Adds FILTER_CYCLES of latency; measured values are unchanged for clean input.
- Undefined: `lvl` is the raw synchroniser output, FILTER_CYCLES is unused, and there is no extra latency.

Decomposition:
- Package pwm_pkg holds:
  - typedef enum logic {IDLE, MEASURE} pwm_cap_state_t.
  - Default width constant PWM_DEFAULT_WIDTH=16, shared with the generator.
  - Default generator period constant (1<<(WIDTH-1)), so the bench can predict reset behaviour.
- Sub-module pwm_input_conditioner: synchroniser, optional deglitch filter, and rise detector. Outputs `lvl` and `rise`.

Test Plan:
- Generator loopback, period=10, duty=3 -> after first discarded period, every 10 cycles measurement_valid=1 with measured_period=10, measured_high=3; period_start every 10 cycles.
- Parameter change mid-stream, period 10/duty 3 to period 20/duty 15 -> one measurement 10/3, then steady 20/15, with no bogus values.
- Constant low (generator after reset, duty 0), TIMEOUT=50 -> no valid; level_stuck=1, stuck_level=0 at about 50 cycles after the last edge. Then duty=5, period=8 -> level_stuck clears on first edge, next valid reports 8/5.
- Constant high (duty=period=8), TIMEOUT=50 -> level_stuck=1, stuck_level=1, no valid.
- Reset asserted 4 cycles into a period 10/duty 3 stream -> all outputs 0 next cycle; the first valid after release comes only after two rising edges, reporting 10/3.
- With PWM_CAPTURE_GLITCH_FILTER_EN, FILTER_CYCLES=4: 2-cycle high glitch inside the low phase of a 20/8 waveform -> glitch ignored, report 20/8. Without the macro, the same stimulus -> extra rise, split measurement reported.
